out_display: RTL and testbench

Downstream consumer of the CPU's 8-bit output register. On each load strobe it captures the output byte and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, optionally treating the byte as two's complement. It drives a time-multiplexed 4-digit common-anode 7-segment display: ones, tens, hundreds and sign. This is the board-facing end of the datapath.

---
 rtl/out_display.sv | 173 +++++++++++++++++
 tb/tb_out_display.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/out_display.sv
// out_display: board-facing end of the datapath. Captures the CPU output byte on a load strobe,
// converts it to three BCD digits with a sequential shift-add-3 engine (optionally as two's
// complement), and drives a time-multiplexed 4-digit common-anode 7-segment display.
//
// Parameters:
//   SCAN_DIV - clk cycles each digit stays lit (2..2^20)
//   SIGNED   - 1: data is two's complement, digit 3 shows '-' for negatives; 0: digit 3 blank
// Ports:
//   clk  - system clock, rising edge
//   clr  - synchronous active-high reset
//   load - one-cycle capture strobe for data (ignored while busy)
//   data - byte from the CPU output register
//   busy - conversion in progress
//   done - one-cycle pulse when new digits are committed
//   bcd  - committed digits {hundreds, tens, ones}
//   neg  - committed sign flag
//   an   - active-low one-hot digit enables, an[0] = ones
//   seg  - active-low segments {dp,g,f,e,d,c,b,a}
module out_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          SIGNED   = 1'b0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  data,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic        neg,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [7:0]      mag_q, mag_d;
    logic [11:0]     scratch_q, scratch_d;
    logic            sign_q, sign_d;
    logic [11:0]     bcd_q, bcd_d;
    logic            neg_q, neg_d;
    logic            done_q, done_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;

    logic [11:0]     adj;
    logic [19:0]     shifted;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // One double-dabble step: correct nibbles >= 5, then shift {scratch, magnitude} left.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            adj[4*n +: 4] = (scratch_q[4*n +: 4] >= 4'd5) ? scratch_q[4*n +: 4] + 4'd3
                                                           : scratch_q[4*n +: 4];
        end
        shifted = {adj, mag_q} << 1;
    end

    // Converter next state
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (load) begin
                    sign_d    = data[7] & SIGNED;
                    // 8'h80 negates to itself, which reads as magnitude 128
                    mag_d     = (data[7] & SIGNED) ? (~data + 8'd1) : data;
                    scratch_d = '0;
                    step_d    = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = shifted[19:8];
                mag_d     = shifted[7:0];
                step_d    = step_q + 3'd1;
                if (step_q == 3'd7) state_d = StCommit;
            end
            StCommit: begin
                bcd_d   = scratch_q;
                neg_d   = sign_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan prescaler, digit select and registered segment drive
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CntLast) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d = ~(4'b0001 << idx_d);
        // Built from committed bcd/neg only, so partial conversions never reach the pins
        case (idx_d)
            2'd0: seg_d = seg7(bcd_q[3:0]);
            2'd1: seg_d = (bcd_q[11:4] == 8'h00) ? 8'hFF : seg7(bcd_q[7:4]);
            2'd2: seg_d = (bcd_q[11:8] == 4'h0) ? 8'hFF : seg7(bcd_q[11:8]);
            default: seg_d = neg_q ? 8'hBF : 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            step_q    <= '0;
            mag_q     <= '0;
            scratch_q <= '0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1110;
            seg_q     <= 8'hC0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_out_display.sv
// Directed, table-driven bench for out_display. Two instances (unsigned and signed) share clock,
// reset and load inputs; each vector is checked on the instance its mode selects.
module tb_out_display;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        busy_u, done_u, neg_u, busy_s, done_s, neg_s;
    logic [11:0] bcd_u, bcd_s;
    logic [3:0]  an_u, an_s;
    logic [7:0]  seg_u, seg_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    out_display #(.SCAN_DIV(4), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .clr(clr), .load(load), .data(data), .busy(busy_u), .done(done_u),
        .bcd(bcd_u), .neg(neg_u), .an(an_u), .seg(seg_u)
    );

    out_display #(.SCAN_DIV(4), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .clr(clr), .load(load), .data(data), .busy(busy_s), .done(done_s),
        .bcd(bcd_s), .neg(neg_s), .an(an_s), .seg(seg_s)
    );

    typedef struct {
        logic [7:0]  data;
        bit          sgn;
        logic [11:0] bcd;
        logic        neg;
        logic [31:0] segs;  // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load d at E0 and check the converter timeline through E10.
    task automatic convert(input logic [7:0] d, input bit s);
        load = 1'b1;
        data = d;
        tick();
        load = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("busy_E%0d", i), s ? busy_s : busy_u, 1);
            chk($sformatf("done_E%0d", i), s ? done_s : done_u, 0);
            tick();
        end
        chk("done_E9", s ? done_s : done_u, 1);
        chk("busy_E9", s ? busy_s : busy_u, 0);
        tick();
        chk("done_E10", s ? done_s : done_u, 0);
    endtask

    // Align to the first cycle of digit 0, then check every cycle of one full scan.
    task automatic scan(input bit s, input logic [31:0] segs);
        logic [3:0] prev;
        logic [3:0] exp_an;
        logic [31:0] sv;
        bit found;
        found = 1'b0;
        prev = s ? an_s : an_u;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if ((s ? an_s : an_u) == 4'b1110 && prev != 4'b1110) found = 1'b1;
            else prev = s ? an_s : an_u;
        end
        if (!found) begin
            chk("scan_align", 0, 1);
        end else begin
            sv = segs;
            for (int k = 0; k < 16; k++) begin
                exp_an = ~(4'b0001 << (k / 4));
                chk($sformatf("an_c%0d", k), s ? an_s : an_u, exp_an);
                chk($sformatf("seg_c%0d", k), s ? seg_s : seg_u, sv[8*(k/4) +: 8]);
                tick();
            end
        end
    endtask

    initial begin
        int ndone;
        int at;

        vecs[0] = '{8'hFF, 1'b0, 12'h255, 1'b0, 32'hFFA49292};
        vecs[1] = '{8'hF6, 1'b1, 12'h010, 1'b1, 32'hBFFFF9C0};
        vecs[2] = '{8'h80, 1'b1, 12'h128, 1'b1, 32'hBFF9A480};
        vecs[3] = '{8'h7F, 1'b1, 12'h127, 1'b0, 32'hFFF9A4F8};
        vecs[4] = '{8'h00, 1'b0, 12'h000, 1'b0, 32'hFFFFFFC0};
        vecs[5] = '{8'hF6, 1'b0, 12'h246, 1'b0, 32'hFFA49982};
        vecs[6] = '{8'h80, 1'b0, 12'h128, 1'b0, 32'hFFF9A480};
        vecs[7] = '{8'h05, 1'b1, 12'h005, 1'b0, 32'hFFFFFF92};
        vecs[8] = '{8'hFF, 1'b1, 12'h001, 1'b1, 32'hBFFFFFF9};

        // Reset
        clr = 1'b1;
        tick();
        tick();
        chk("rst_an", an_u, 4'b1110);
        chk("rst_seg", seg_u, 8'hC0);
        chk("rst_busy", busy_u, 0);
        chk("rst_bcd", bcd_u, 12'h000);
        chk("rst_done", done_u, 0);
        chk("rst_neg_s", neg_s, 0);
        clr = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_u || done_s) ndone++;
        end
        chk("rst_no_done", ndone, 0);

        // Table vectors
        foreach (vecs[v]) begin
            convert(vecs[v].data, vecs[v].sgn);
            chk($sformatf("bcd_v%0d", v), vecs[v].sgn ? bcd_s : bcd_u, vecs[v].bcd);
            chk($sformatf("neg_v%0d", v), vecs[v].sgn ? neg_s : neg_u, vecs[v].neg);
            chk($sformatf("neg_u_v%0d", v), neg_u, 0);
            scan(vecs[v].sgn, vecs[v].segs);
        end

        // Load while busy: second load at E3 must vanish
        load = 1'b1;
        data = 8'd7;
        tick();
        load = 1'b0;
        tick();
        tick();
        load = 1'b1;
        data = 8'd9;
        tick();
        load = 1'b0;
        ndone = 0;
        at = -1;
        for (int i = 4; i <= 16; i++) begin
            tick();
            if (done_u) begin
                ndone++;
                at = i;
            end
        end
        chk("busy_load_ndone", ndone, 1);
        chk("busy_load_at", at, 9);
        chk("busy_load_bcd", bcd_u, 12'h007);
        scan(1'b0, 32'hFFFFFFF8);

        // Reset mid-conversion at E4
        load = 1'b1;
        data = 8'd200;
        tick();
        load = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy_pre", busy_u, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("mid_busy", busy_u, 0);
        chk("mid_bcd", bcd_u, 12'h000);
        chk("mid_an", an_u, 4'b1110);
        chk("mid_seg", seg_u, 8'hC0);
        chk("mid_done", done_u, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_u) ndone++;
        end
        chk("mid_no_done", ndone, 0);
        chk("mid_bcd_hold", bcd_u, 12'h000);

        convert(8'd5, 1'b0);
        chk("after_mid_bcd", bcd_u, 12'h005);
        scan(1'b0, 32'hFFFFFF92);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
